// File: rtl/canny_pkg.sv
// Shared constants, edge codes and sequencer state type for the Canny window sequencer.
package canny_pkg;

   localparam int PIX_W          = 24;
   localparam int N_ELEM         = 9;
   localparam int WIN_W          = PIX_W * N_ELEM;
   localparam int TIMEOUT_CYCLES = 255;

   localparam logic [7:0] EDGE_NONE   = 8'd0;
   localparam logic [7:0] EDGE_WEAK   = 8'd128;
   localparam logic [7:0] EDGE_STRONG = 8'd255;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      CLR   = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   function automatic logic is_last_idx(input logic [3:0] idx);
      return idx == 4'(N_ELEM - 1);
   endfunction

endpackage

// File: rtl/canny_win_serializer.sv
// Holds the captured core result and streams the low byte of each element out
// as a valid/ready stream while the sequencer is in DRAIN.
module canny_win_serializer
   import canny_pkg::*;
(
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_capture,
   input  logic             i_flush,
   input  logic [WIN_W-1:0] i_gm,
   input  logic             i_drain,
   input  logic             i_m_ready,
   output logic [7:0]       o_m_pix,
   output logic             o_m_valid,
   output logic             o_m_last,
   output logic             o_win_done
);

   logic [WIN_W-1:0] r_gm_q;
   logic [3:0]       r_idx;
   logic [7:0]       w_byte;
   logic             w_last;

   assign w_last = is_last_idx(r_idx);
   assign w_byte = r_gm_q[32'(r_idx)*PIX_W +: 8];

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_gm_q <= '0;
         r_idx  <= '0;
      end else begin
         // A watchdog abort loads zeros so the window drains as all EDGE_NONE
         if (i_capture)
            r_gm_q <= i_gm;
         else if (i_flush)
            r_gm_q <= '0;
         if (i_drain && i_m_ready)
            r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
      end
   end

   assign o_m_valid  = i_drain;
   assign o_m_pix    = i_drain ? w_byte : EDGE_NONE;
   assign o_m_last   = i_drain && w_last;
   assign o_win_done = i_drain && i_m_ready && w_last;

endmodule

// File: rtl/canny_win_sequencer.sv
// Drives the 3x3 Canny core: packs nine pixels, pulses core reset, runs the core
// and drains the edge codes. Optional RUN watchdog enabled by WIN_TIMEOUT_EN.
//
// state | meaning
// LOAD  | accept pixels into the window until nine are held
// CLR   | one-cycle core reset, re-arms the core for this window
// RUN   | core enabled, waiting for done (or watchdog)
// DRAIN | stream nine edge codes out
module canny_win_sequencer
   import canny_pkg::*;
(
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [PIX_W-1:0] i_s_pix,
   input  logic             i_s_valid,
   output logic             o_s_ready,
   output logic             o_core_rst,
   output logic             o_core_en,
   output logic [WIN_W-1:0] o_core_a,
   input  logic [WIN_W-1:0] i_core_gm,
   input  logic             i_core_done,
   output logic [7:0]       o_m_pix,
   output logic             o_m_valid,
   input  logic             i_m_ready,
   output logic             o_m_last,
   output logic             o_busy,
   output logic [15:0]      o_win_count,
   output logic             o_err
);

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_idx;
   logic [WIN_W-1:0] r_core_a;
   logic [15:0]      r_win_count;
   logic             w_accept;
   logic             w_core_hit;
   logic             w_tmo;
   logic             w_win_done;

   assign w_accept   = (r_state == LOAD) && i_s_valid;
   assign w_core_hit = (r_state == RUN) && i_core_done;

`ifdef WIN_TIMEOUT_EN
   logic [8:0] r_tmo;
   logic       r_err;

   assign w_tmo = (r_state == RUN) && !i_core_done && (r_tmo == 9'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state == CLR)
            r_tmo <= '0;
         else if (r_state == RUN)
            r_tmo <= r_tmo + 9'd1;
         if (w_tmo)
            r_err <= 1'b1;
      end
   end

   assign o_err = r_err;
`else
   assign w_tmo = 1'b0;
   assign o_err = 1'b0;
`endif

   always_comb begin
      w_next     = r_state;
      o_s_ready  = 1'b0;
      o_core_rst = 1'b0;
      o_core_en  = 1'b0;
      o_busy     = 1'b1;
      case (r_state)
         LOAD: begin
            o_s_ready = 1'b1;
            o_busy    = 1'b0;
            if (w_accept && is_last_idx(r_idx))
               w_next = CLR;
         end
         CLR: begin
            o_core_rst = 1'b1;
            w_next     = RUN;
         end
         RUN: begin
            o_core_en = 1'b1;
            if (w_core_hit || w_tmo)
               w_next = DRAIN;
         end
         DRAIN: begin
            if (w_win_done)
               w_next = LOAD;
         end
         default: w_next = LOAD;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= LOAD;
         r_idx       <= '0;
         r_core_a    <= '0;
         r_win_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_core_a[32'(r_idx)*PIX_W +: PIX_W] <= i_s_pix;
            r_idx <= is_last_idx(r_idx) ? 4'd0 : r_idx + 4'd1;
         end
         if (w_win_done)
            r_win_count <= r_win_count + 16'd1;
      end
   end

   canny_win_serializer u_ser (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_capture  (w_core_hit),
      .i_flush    (w_tmo),
      .i_gm       (i_core_gm),
      .i_drain    (r_state == DRAIN),
      .i_m_ready  (i_m_ready),
      .o_m_pix    (o_m_pix),
      .o_m_valid  (o_m_valid),
      .o_m_last   (o_m_last),
      .o_win_done (w_win_done)
   );

   assign o_core_a    = r_core_a;
   assign o_win_count = r_win_count;

endmodule
